// File: rtl/eth_rx_pkg.sv
// Shared constants and FSM state type for the RMII receive frame controller.
package eth_rx_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_LEN   = 64;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    DROP,
    CHECK
  } rx_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts LSB first, so the bytewise update uses the bit-reversed polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
module eth_crc32_byte
  import eth_rx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_next_crc
);

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  assign o_next_crc = crc_step(i_crc, i_byte);

endmodule

// File: rtl/rmii_rx_frame_ctrl.sv
// Receive frame controller: DA filter, FCS check, ping-pong buffer writes and
// oldest-first handoff of completed frames to the host side.
module rmii_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int AW      = 11,
  parameter int MIN_LEN = ETH_MIN_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_rdy,
  input  logic          rx_busy,
  input  logic [47:0]   my_mac,
  input  logic          promisc,
  output logic          buf_we,
  output logic [AW:0]   buf_addr,
  output logic [7:0]    buf_wdata,
  output logic          frm_valid,
  output logic          frm_bank,
  output logic [AW:0]   frm_len,
  input  logic          frm_ack,
  output logic [15:0]   cnt_crc_err,
  output logic [15:0]   cnt_ovf
);

  localparam logic [AW:0] LAST_OFFS = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] HDR_LAST  = (AW+1)'(5);
  localparam logic [AW:0] MIN_LEN_C = (AW+1)'(MIN_LEN);
  localparam logic [AW:0] FCS_LEN   = (AW+1)'(4);

  rx_state_t   r_state, w_state_nxt;
  logic        r_busy_d;
  logic [AW:0] r_offs;
  logic        r_bank;
  logic [31:0] r_crc;
  logic        r_da_my, r_da_bc;
  logic        r_we;
  logic [AW:0] r_addr;
  logic [7:0]  r_wdata;
  logic [1:0]  r_full;
  logic [1:0]  r_q_cnt;
  logic        r_q_bank0, r_q_bank1;
  logic [AW:0] r_q_len0, r_q_len1;
  logic [15:0] r_cnt_err, r_cnt_ovf;

  logic        w_rise, w_fall, w_wr, w_start, w_push, w_pop;
  logic        w_inc_err, w_inc_ovf;
  logic        w_my_ok, w_bc_ok, w_free_any, w_free_bank;
  logic [7:0]  w_mac_byte;
  logic [31:0] w_crc_next;
  logic [AW:0] w_new_len;
  logic [1:0]  w_set, w_clr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  eth_crc32_byte u_crc (
    .i_crc      (r_crc),
    .i_byte     (rx_data),
    .o_next_crc (w_crc_next)
  );

  assign w_rise      = rx_busy & ~r_busy_d;
  assign w_fall      = ~rx_busy & r_busy_d;
  assign w_wr        = rx_rdy & ((r_state == HDR) | (r_state == DATA));
  assign w_free_any  = ~&r_full;
  assign w_free_bank = r_full[0];
  assign w_my_ok     = r_da_my & (rx_data == w_mac_byte);
  assign w_bc_ok     = r_da_bc & (rx_data == BCAST_MAC[7:0]);
  assign w_new_len   = r_offs - FCS_LEN;
  assign w_pop       = frm_ack & (r_q_cnt != 2'd0);
  assign w_set       = {w_push & r_bank, w_push & ~r_bank};
  assign w_clr       = {w_pop & r_q_bank0, w_pop & ~r_q_bank0};

  always_comb begin
    case (r_offs[2:0])
      3'd0:    w_mac_byte = my_mac[47:40];
      3'd1:    w_mac_byte = my_mac[39:32];
      3'd2:    w_mac_byte = my_mac[31:24];
      3'd3:    w_mac_byte = my_mac[23:16];
      3'd4:    w_mac_byte = my_mac[15:8];
      3'd5:    w_mac_byte = my_mac[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_inc_err   = 1'b0;
    w_inc_ovf   = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          if (w_free_any) begin
            w_state_nxt = HDR;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = DROP;
            w_inc_ovf   = 1'b1;
          end
        end
      end
      HDR: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_inc_err   = 1'b1;
        end else if (rx_rdy && r_offs == HDR_LAST) begin
          w_state_nxt = (promisc || w_my_ok || w_bc_ok) ? DATA : DROP;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_state_nxt = CHECK;
        end else if (rx_rdy && r_offs == LAST_OFFS) begin
          w_state_nxt = DROP;
          w_inc_ovf   = 1'b1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        if (r_offs < MIN_LEN_C || r_crc != CRC32_RESIDUE) w_inc_err = 1'b1;
        else                                               w_push    = 1'b1;
      end
      DROP: begin
        if (w_fall) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Running FCS and DA match flags; seeded at frame start, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_crc   <= '1;
      r_da_my <= 1'b1;
      r_da_bc <= 1'b1;
    end else if (w_wr) begin
      r_crc   <= w_crc_next;
      r_da_my <= w_my_ok;
      r_da_bc <= w_bc_ok;
    end
  end

  // Busy edge detect preset high so a frame already running at reset release is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_d <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_offs   <= '0;
      r_bank   <= 1'b0;
    end else begin
      r_busy_d <= rx_busy;
      r_we     <= w_wr;
      if (w_start) begin
        r_offs <= '0;
        r_bank <= w_free_bank;
      end else if (w_wr) begin
        r_offs  <= r_offs + 1'b1;
        r_addr  <= {r_bank, r_offs[AW-1:0]};
        r_wdata <= rx_data;
      end
    end
  end

  // Two-entry order FIFO; a push and pop in the same cycle keep the oldest frame at the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_q_cnt   <= '0;
      r_q_bank0 <= 1'b0;
      r_q_bank1 <= 1'b0;
      r_q_len0  <= '0;
      r_q_len1  <= '0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_q_cnt == 2'd0) begin
            r_q_bank0 <= r_bank;
            r_q_len0  <= w_new_len;
          end else begin
            r_q_bank1 <= r_bank;
            r_q_len1  <= w_new_len;
          end
          r_q_cnt <= r_q_cnt + 2'd1;
        end
        2'b01: begin
          r_q_bank0 <= r_q_bank1;
          r_q_len0  <= r_q_len1;
          r_q_cnt   <= r_q_cnt - 2'd1;
        end
        2'b11: begin
          if (r_q_cnt == 2'd1) begin
            r_q_bank0 <= r_bank;
            r_q_len0  <= w_new_len;
          end else begin
            r_q_bank0 <= r_q_bank1;
            r_q_len0  <= r_q_len1;
            r_q_bank1 <= r_bank;
            r_q_len1  <= w_new_len;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_err <= '0;
      r_cnt_ovf <= '0;
    end else begin
      if (w_inc_err) r_cnt_err <= sat_inc(r_cnt_err);
      if (w_inc_ovf) r_cnt_ovf <= sat_inc(r_cnt_ovf);
    end
  end

  assign buf_we      = r_we;
  assign buf_addr    = r_addr;
  assign buf_wdata   = r_wdata;
  assign frm_valid   = (r_q_cnt != 2'd0);
  assign frm_bank    = r_q_bank0;
  assign frm_len     = r_q_len0;
  assign cnt_crc_err = r_cnt_err;
  assign cnt_ovf     = r_cnt_ovf;

endmodule
